// File: rtl/lc3b_types.sv
// Shared LC-3b types: physical-memory line, arbiter state encoding, starvation ceiling.
package lc3b_types;

  localparam int PLINE_W        = 128;
  localparam int ARB_STARVE_MAX = 15;

  typedef logic [PLINE_W-1:0] lc3b_pline;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of D grants made while I waits; flags when I must be forced next.
// Latency: count updates on the grant edge; forced is combinational from the count.
module arb_starve_counter
  import lc3b_types::*;
#(
  parameter int LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       forced
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != 4'(ARB_STARVE_MAX))) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign forced = (int'(cnt) >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// I-cache / D-cache arbiter for one pmem line port: data priority, fetch anti-starvation, grant held per access.
// Request at edge k -> strobe from k+1; pmem_resp passes straight through; one IDLE cycle between grants. Optional MEM_ARB_PERF_EN.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W       = 16,
  parameter int LINE_W       = PLINE_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef MEM_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_i_wait
`endif
);

  arb_state_t state_q, state_d;
  logic       d_req;
  logic       forced_i;
  logic       starve_inc;
  logic       starve_clr;
  logic [3:0] starve_cnt;

  assign d_req   = d_read | d_write;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .cnt    (starve_cnt),
    .forced (forced_i)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // pmem_resp is deliberately ignored here: nothing is outstanding.
        if (d_req && !forced_i) begin
          state_d    = ARB_SERVE_D;
          starve_inc = i_read;
        end else if (i_read) begin
          state_d    = ARB_SERVE_I;
          starve_clr = 1'b1;
        end
      end
      ARB_SERVE_I: begin
        pmem_read = 1'b1;
        pmem_addr = i_addr;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      ARB_SERVE_D: begin
        pmem_read  = d_read & ~d_write;
        pmem_write = d_write;
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
        if (pmem_resp) begin
          d_resp  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_i_grants <= '0;
      perf_d_grants <= '0;
      perf_i_wait   <= '0;
    end else if (perf_clr) begin
      perf_i_grants <= '0;
      perf_d_grants <= '0;
      perf_i_wait   <= '0;
    end else begin
      if (state_q == ARB_IDLE && state_d == ARB_SERVE_I) perf_i_grants <= perf_i_grants + 32'd1;
      if (state_q == ARB_IDLE && state_d == ARB_SERVE_D) perf_d_grants <= perf_d_grants + 32'd1;
      if (i_read && state_q != ARB_SERVE_I)              perf_i_wait   <= perf_i_wait + 32'd1;
    end
  end
`endif

  // Simultaneous read and write-back from the dcache is illegal; write would win.
  a_no_rd_wr: assert property (@(posedge clk) disable iff (reset)
    !(state_q == ARB_SERVE_D && d_read && d_write))
    else $error("mem_arbiter: d_read and d_write both high");

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, randomized run vs. a request-level model.
module tb_mem_arbiter;
  import lc3b_types::*;

  localparam int AW = 16;
  localparam int LW = 128;
  localparam int LIMIT = 4;

  typedef logic [149:0] obs_t;

  typedef struct {
    logic        ir, dr, dw;
    logic [15:0] ia, da;
    logic        presp;
    logic        e_pr, e_pw;
    logic [15:0] e_addr;
    logic        e_ir, e_dr, e_wd;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_addr;
`ifdef MEM_ARB_PERF_EN
  logic          perf_clr;
  logic [31:0]   perf_i_grants, perf_d_grants, perf_i_wait;
`endif

  int nvec = 0;
  int nmis = 0;
  int pm_cnt = 0;
  int pm_lat = 1;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef MEM_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_i_grants(perf_i_grants),
    .perf_d_grants(perf_d_grants), .perf_i_wait(perf_i_wait)
`endif
  );

  function automatic obs_t obs(logic pr, logic pw, logic [15:0] a, logic ir, logic dr,
                               logic [127:0] wd, logic m1, logic m2);
    return {pr, pw, a, ir, dr, wd, m1, m2};
  endfunction

  function automatic obs_t dut_obs();
    return obs(pmem_read, pmem_write, pmem_addr, i_resp, d_resp, pmem_wdata,
               i_rdata == pmem_rdata, d_rdata == pmem_rdata);
  endfunction

  function automatic vec_t mk(logic ir, logic dr, logic dw, logic [15:0] ia, logic [15:0] da,
                              logic presp, logic e_pr, logic e_pw, logic [15:0] e_addr,
                              logic e_ir, logic e_dr, logic e_wd);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.presp = presp;
    v.e_pr = e_pr; v.e_pw = e_pw; v.e_addr = e_addr; v.e_ir = e_ir; v.e_dr = e_dr; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural pmem: answers each strobe after a random 1..4 cycle latency.
  task automatic pmem_step(input bit spurious);
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      pm_cnt    = 0;
    end else if (pmem_read || pmem_write) begin
      if (pm_cnt == 0) pm_lat = int'($urandom_range(1, 4));
      pm_cnt++;
      if (pm_cnt >= pm_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end else if (spurious && $urandom_range(0, 15) == 0) begin
      pmem_resp = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0; pm_cnt = 0;
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic txn(input bit is_d);
    bit got = 0;
    @(negedge clk);
    if (is_d) begin d_read = 1; d_addr = 16'h7000; end
    else      begin i_read = 1; i_addr = 16'h1000; end
    for (int c = 0; c < 30; c++) begin
      #1; pmem_step(1'b0); #1;
      if (i_resp || d_resp) begin got = 1; break; end
      @(negedge clk);
    end
    chk("txn_done", obs_t'(got), obs_t'(1));
    @(negedge clk);
    idle_inputs();
  endtask
`endif

  initial begin
    vec_t        vecs[$];
    lc3b_pline   wd_pat;
    lc3b_pline   a5_pat;
    int          m_owner, m_starve, nd;
    bit          got_i, i_done, d_done;
    logic [15:0] e_addr;
    logic        e_pr, e_pw, e_ir, e_dr;
    lc3b_pline   e_wd;

    wd_pat = {4{32'hC0DE_F00D}};
    a5_pat = {16{8'hA5}};
    reset = 1; i_addr = 0; d_addr = 0; d_wdata = wd_pat; pmem_rdata = a5_pat;
    idle_inputs();
`ifdef MEM_ARB_PERF_EN
    perf_clr = 0;
`endif

    // I alone at 0x1230, pmem answers on the 6th strobe cycle.
    vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,0,0,0));
    vecs.push_back(mk(1,0,0,16'h1230,16'h0000,0, 0,0,16'h0000,0,0,0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1,0,0,16'h1230,16'h0000,0, 1,0,16'h1230,0,0,0));
    vecs.push_back(mk(1,0,0,16'h1230,16'h0000,1, 1,0,16'h1230,1,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,0,0,0));
    // I and D write together: D first, one IDLE cycle, then I.
    vecs.push_back(mk(1,0,1,16'h2000,16'h4000,0, 0,0,16'h0000,0,0,0));
    vecs.push_back(mk(1,0,1,16'h2000,16'h4000,0, 0,1,16'h4000,0,0,1));
    vecs.push_back(mk(1,0,1,16'h2000,16'h4000,1, 0,1,16'h4000,0,1,1));
    vecs.push_back(mk(1,0,0,16'h2000,16'h4000,0, 0,0,16'h0000,0,0,0));
    vecs.push_back(mk(1,0,0,16'h2000,16'h4000,0, 1,0,16'h2000,0,0,0));
    vecs.push_back(mk(1,0,0,16'h2000,16'h4000,1, 1,0,16'h2000,1,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,0,0,0));
    // pmem_resp while IDLE is ignored.
    vecs.push_back(mk(0,0,0,16'h0000,16'h0000,1, 0,0,16'h0000,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,0,0,0));
    // D read alone.
    vecs.push_back(mk(0,1,0,16'h0000,16'h5550,0, 0,0,16'h0000,0,0,0));
    vecs.push_back(mk(0,1,0,16'h0000,16'h5550,0, 1,0,16'h5550,0,0,1));
    vecs.push_back(mk(0,1,0,16'h0000,16'h5550,1, 1,0,16'h5550,0,1,1));
    vecs.push_back(mk(0,0,0,16'h0000,16'h0000,0, 0,0,16'h0000,0,0,0));

    #1;
    chk("reset_outputs", dut_obs(), obs(0,0,16'h0,0,0,'0,1,1));
    @(negedge clk);
    reset = 0;

    foreach (vecs[n]) begin
      @(negedge clk);
      i_read = vecs[n].ir; d_read = vecs[n].dr; d_write = vecs[n].dw;
      i_addr = vecs[n].ia; d_addr = vecs[n].da; pmem_resp = vecs[n].presp;
      #1;
      chk($sformatf("vec%0d", n), dut_obs(),
          obs(vecs[n].e_pr, vecs[n].e_pw, vecs[n].e_addr, vecs[n].e_ir, vecs[n].e_dr,
              vecs[n].e_wd ? wd_pat : '0, 1, 1));
    end

    // Starvation: D re-requests every IDLE cycle while I is held.
    @(negedge clk);
    idle_inputs();
    i_read = 1; i_addr = 16'h3000; d_read = 1; d_addr = 16'h6000;
    nd = 0; got_i = 0;
    for (int c = 0; c < 300 && !got_i; c++) begin
      #1; pmem_step(1'b0); #1;
      if (d_resp) nd++;
      if (i_resp) got_i = 1;
      else @(negedge clk);
    end
    chk("starve_i_granted", obs_t'(got_i), obs_t'(1));
    chk("starve_d_grants", obs_t'(nd), obs_t'(LIMIT));
    @(negedge clk);
    idle_inputs();
    #1;
    chk("starve_cnt_cleared", obs_t'(dut.starve_cnt), obs_t'(0));

    // Asynchronous reset in the middle of a D write-back.
    @(negedge clk);
    d_write = 1; d_addr = 16'h4000; i_read = 1; i_addr = 16'h2000;
    @(negedge clk);
    #1;
    chk("pre_reset_write", obs_t'({pmem_write, pmem_addr}), obs_t'({1'b1, 16'h4000}));
    chk("pre_reset_starve", obs_t'(dut.starve_cnt), obs_t'(1));
    #1 reset = 1;
    #1;
    chk("reset_drops_strobes", obs_t'({pmem_read, pmem_write}), obs_t'(0));
    @(negedge clk);
    reset = 0;
    idle_inputs();
    #1;
    chk("post_reset_state", obs_t'({dut.state_q, dut.starve_cnt}), obs_t'({ARB_IDLE, 4'd0}));

    // Randomized traffic against a request-level model of the arbitration rules.
    m_owner = 0; m_starve = 0; i_done = 0; d_done = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (i_done) begin i_read = 0; i_done = 0; end
      else if (!i_read && $urandom_range(0, 2) == 0) begin i_read = 1; i_addr = 16'($urandom); end
      if (d_done) begin d_read = 0; d_write = 0; d_done = 0; end
      else if (!(d_read || d_write) && $urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 1) == 0) d_write = 1; else d_read = 1;
        d_addr  = 16'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      #1; pmem_step(1'b1); #1;
      e_pr = 0; e_pw = 0; e_addr = '0; e_wd = '0; e_ir = 0; e_dr = 0;
      if (m_owner == 1) begin
        e_pr = 1; e_addr = i_addr; e_ir = pmem_resp;
      end else if (m_owner == 2) begin
        e_pr = d_read & ~d_write; e_pw = d_write; e_addr = d_addr; e_wd = d_wdata; e_dr = pmem_resp;
      end
      chk($sformatf("rand%0d", c), dut_obs(), obs(e_pr, e_pw, e_addr, e_ir, e_dr, e_wd, 1, 1));
      i_done = e_ir;
      d_done = e_dr;
      if (m_owner == 0) begin
        if ((d_read || d_write) && m_starve < LIMIT) begin
          m_owner = 2;
          if (i_read && m_starve < ARB_STARVE_MAX) m_starve++;
        end else if (i_read) begin
          m_owner = 1;
          m_starve = 0;
        end
      end else if (pmem_resp) begin
        m_owner = 0;
      end
    end

    @(negedge clk);
    idle_inputs();
    @(negedge clk);

`ifdef MEM_ARB_PERF_EN
    perf_clr = 1;
    @(negedge clk);
    perf_clr = 0;
    txn(0); txn(1); txn(0); txn(1); txn(0);
    @(negedge clk);
    chk("perf_i_grants", obs_t'(perf_i_grants), obs_t'(3));
    chk("perf_d_grants", obs_t'(perf_d_grants), obs_t'(2));
    perf_clr = 1;
    @(negedge clk);
    perf_clr = 0;
    #1;
    chk("perf_clr", obs_t'({perf_i_grants, perf_d_grants, perf_i_wait}), obs_t'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache (fetch stage) and the data cache (MEM stage) of the pipelined LC-3b.
- Sits between both cache miss paths and pmem.
- Uses fixed data-side priority with an anti-starvation counter for the fetch side.
- Registers the grant and holds it for the whole transaction.

Parameters:
- ADDR_W, 16, physical byte address width.
- LINE_W, 128, cache line width in bits.
- STARVE_LIMIT, 4, consecutive D grants made while I is waiting before I is forced next; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_read  in  1  icache line read request; held until i_resp.
- i_addr  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  line returned to icache.
- i_resp  out  1  one-cycle completion to icache.
- d_read  in  1  dcache line read request.
- d_write  in  1  dcache line write-back request.
- d_addr  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  write-back line.
- d_rdata  out  LINE_W  line returned to dcache.
- d_resp  out  1  one-cycle completion to dcache.
- pmem_read  out  1  physical read strobe, level, held until pmem_resp.
- pmem_write  out  1  physical write strobe, level, held until pmem_resp.
- pmem_addr  out  ADDR_W  physical address.
- pmem_wdata  out  LINE_W  physical write data.
- pmem_rdata  in  LINE_W  physical read data.
- pmem_resp  in  1  physical completion, one cycle.

Behaviour:
- Reset (asynchronous): state = IDLE, starve_cnt = 0, all strobes and resps = 0, pmem_addr/pmem_wdata = 0.
- States and transitions:
  - IDLE:
    - d_req (d_read|d_write) and not forced-I -> SERVE_D.
    - i_read and (no d_req or forced-I) -> SERVE_I.
    - Otherwise stay in IDLE.
  - SERVE_I: pmem_read = 1, pmem_addr = i_addr. On pmem_resp: i_resp = 1 combinationally in the same cycle, i_rdata = pmem_rdata, next state IDLE.
  - SERVE_D:
    - pmem_read = d_read & ~d_write; pmem_write = d_write; pmem_addr = d_addr; pmem_wdata = d_wdata.
    - On pmem_resp: d_resp = 1, d_rdata = pmem_rdata, next state IDLE.
    - d_read and d_write both high: write wins; this is illegal stimulus and an assertion flags it.
- forced-I = (starve_cnt >= STARVE_LIMIT).
- starve_cnt:
  - Increments on each IDLE->SERVE_D transition while i_read = 1.
  - Clears on IDLE->SERVE_I.
  - Saturates at 15.
- Latency:
  - A request seen at edge k enters SERVE at k+1; pmem strobe is high from cycle k+1.
  - Response passes through with zero cycles of added delay.
  - Minimum 1 IDLE cycle between transactions, so back-to-back throughput = pmem latency + 1.
- Outputs are state-decoded; no strobes are asserted in IDLE.
- i_rdata and d_rdata always mirror pmem_rdata; they are valid only when the matching resp is high.
- Requesters must drop their request the cycle after resp. The arbiter never samples a request in the resp cycle.
- Address or data changes during SERVE are forwarded unfiltered; requesters hold them stable.
- pmem_resp in IDLE is ignored; no resp is generated.
- Reset mid-transaction aborts to IDLE and drops strobes; pmem must tolerate an abandoned access.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_i_grants[31:0], perf_d_grants[31:0] and perf_i_wait[31:0].
  - perf_i_wait counts cycles with i_read high while not in SERVE_I.
  - All three counters wrap, reset to 0, and clear synchronously on new input perf_clr.
- Undefined: ports and logic are absent; arbitration is identical.

Decomposition:
- lc3b_types package gains:
  - lc3b_pline (LINE_W-bit line typedef).
  - arb_state_t enum {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
  - ARB_STARVE_MAX = 15 constant.
- One sub-module: arb_starve_counter (saturating counter with increment, clear and threshold compare).

Test Plan:
- Reset is asserted mid-SERVE_D with pmem_write high -> strobes are 0 immediately (asynchronous); state is IDLE and starve_cnt = 0 after release.
- i_read alone at 0x1230, pmem_resp 5 cycles after the strobe, pmem_rdata = 0xA5..A5 -> pmem_read rises 1 cycle after request, i_resp high for 1 cycle with i_rdata = 0xA5..A5, d_resp stays 0.
- i_read and d_write rise together, addr 0x2000 and 0x4000 -> D is served first with pmem_write and addr 0x4000; after d_resp and one IDLE cycle, I is served at 0x2000.
- d_read continuously re-asserted and i_read held, STARVE_LIMIT = 4 -> exactly 4 D grants, then an I grant; starve_cnt returns to 0.
- pmem_resp pulsed while IDLE -> no i_resp or d_resp, no state change.
- With MEM_ARB_PERF_EN, 3 I and 2 D transactions -> perf_i_grants = 3 and perf_d_grants = 2; perf_clr zeroes all counters.
